// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin denominations, out_coin
// bit positions and the FSM state encoding.
package change_dispenser_pkg;

    localparam int NUM_COINS = 5;

    localparam int COIN_1_BIT  = 0;
    localparam int COIN_5_BIT  = 1;
    localparam int COIN_10_BIT = 2;
    localparam int COIN_20_BIT = 3;
    localparam int COIN_50_BIT = 4;

    localparam logic [7:0] COIN_1_VAL  = 8'd1;
    localparam logic [7:0] COIN_5_VAL  = 8'd5;
    localparam logic [7:0] COIN_10_VAL = 8'd10;
    localparam logic [7:0] COIN_20_VAL = 8'd20;
    localparam logic [7:0] COIN_50_VAL = 8'd50;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic logic [7:0] coin_value(input int bit_idx);
        logic [7:0] val;
        case (bit_idx)
            COIN_1_BIT:  val = COIN_1_VAL;
            COIN_5_BIT:  val = COIN_5_VAL;
            COIN_10_BIT: val = COIN_10_VAL;
            COIN_20_BIT: val = COIN_20_VAL;
            COIN_50_BIT: val = COIN_50_VAL;
            default:     val = 8'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request/status bundle between the dispenser and its controller.
interface change_dispenser_if;
    logic       start;
    logic [7:0] change_money;
    logic       abort;
    logic [4:0] out_coin;
    logic       busy;
    logic       done;
    logic [7:0] remaining;
    logic [3:0] coin_count;

    modport master (
        output start, change_money, abort,
        input  out_coin, busy, done, remaining, coin_count
    );

    modport slave (
        input  start, change_money, abort,
        output out_coin, busy, done, remaining, coin_count
    );
endinterface

// File: rtl/change_dispenser_coin_select.sv
// Greedy denomination picker: largest coin not exceeding remaining, one-hot in
// out_coin bit order plus its value. remaining==0 yields no coin and value 0.
module coin_select
    import change_dispenser_pkg::*;
(
    input  logic [7:0] remaining,
    output logic [4:0] onehot,
    output logic [7:0] value
);

    always_comb begin : pick
        logic found;
        onehot = '0;
        value  = '0;
        found  = 1'b0;
        // Bit order rises with denomination, so scanning downward is greedy.
        for (int i = NUM_COINS - 1; i >= 0; i--) begin
            if (!found && remaining >= coin_value(i)) begin
                onehot[i] = 1'b1;
                value     = coin_value(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: drains a requested amount as timed coin-eject pulses,
// largest denomination first, with abort-after-current-coin.
//
// state  | meaning
// IDLE   | waiting for start; remaining/coin_count hold last result
// SELECT | one cycle, pick the largest coin <= remaining
// PULSE  | out_coin[sel] high for PULSE_CYCLES
// GAP    | out_coin low for GAP_CYCLES
// DONE   | one-cycle completion strobe
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int PULSE_CYCLES = 5000000,
    parameter int GAP_CYCLES   = 5000000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    change_dispenser_if.slave bus
);

    localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW         = ($clog2(MAX_CYCLES) < 1) ? 1 : $clog2(MAX_CYCLES);
    localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

    state_t        state;
    logic [TW-1:0] timer;
    logic          abort_pending;
    logic [7:0]    sel_value;
    logic [4:0]    pick_onehot;
    logic [7:0]    pick_value;

    logic [4:0]    out_coin_r;
    logic          busy_r;
    logic          done_r;
    logic [7:0]    remaining_r;
    logic [3:0]    coin_count_r;

    coin_select u_coin_select (
        .remaining (remaining_r),
        .onehot    (pick_onehot),
        .value     (pick_value)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= ST_IDLE;
            timer         <= '0;
            abort_pending <= 1'b0;
            sel_value     <= '0;
            out_coin_r    <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            remaining_r   <= '0;
            coin_count_r  <= '0;
        end else begin
            done_r <= 1'b0;
            if (bus.abort && state != ST_IDLE) begin
                abort_pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        remaining_r   <= bus.change_money;
                        coin_count_r  <= '0;
                        abort_pending <= 1'b0;
                        busy_r        <= 1'b1;
                        if (bus.change_money == 8'd0) begin
                            done_r <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            state  <= ST_SELECT;
                        end
                    end
                end

                ST_SELECT: begin
                    if (abort_pending) begin
                        done_r <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        out_coin_r <= pick_onehot;
                        sel_value  <= pick_value;
                        timer      <= PULSE_LOAD;
                        state      <= ST_PULSE;
                    end
                end

                ST_PULSE: begin
                    if (timer == '0) begin
                        out_coin_r   <= '0;
                        remaining_r  <= remaining_r - sel_value;
                        coin_count_r <= (coin_count_r == 4'd15) ? 4'd15 : coin_count_r + 4'd1;
                        timer        <= GAP_LOAD;
                        state        <= ST_GAP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                ST_GAP: begin
                    if (timer == '0) begin
                        if (remaining_r == 8'd0 || abort_pending) begin
                            done_r <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            state  <= ST_SELECT;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                ST_DONE: begin
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: begin
                    out_coin_r <= '0;
                    busy_r     <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out_coin   = out_coin_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.remaining  = remaining_r;
    assign bus.coin_count = coin_count_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with PULSE_CYCLES=4, GAP_CYCLES=3.
module tb_change_dispenser;

    logic sys_clk;
    logic sys_rst;
    int   checks;
    int   errors;

    change_dispenser_if bus ();

    change_dispenser #(
        .PULSE_CYCLES (4),
        .GAP_CYCLES   (3)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    typedef struct {
        logic [7:0]  money;
        int          n;
        logic [31:0] seq;
        int          done_c;
        int          rem;
        int          cnt;
        int          inj_cyc;
        int          inj_kind;
        logic [7:0]  inj_money;
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int bit_of(input logic [4:0] oc);
        int r;
        r = -1;
        for (int i = 0; i < 5; i++) if (oc[i]) r = i;
        return r;
    endfunction

    task automatic run_vec(input int vi, input vec_t v);
        int cyc, nr, cur_len, glitch, busy_err, done_c;
        int rise_bit[16];
        int rise_cyc[16];
        int high_len[16];
        logic [4:0] oc, prev;
        string tag;
        for (int i = 0; i < 16; i++) begin
            rise_bit[i] = -1; rise_cyc[i] = -1; high_len[i] = -1;
        end
        nr = 0; cur_len = 0; glitch = 0; busy_err = 0; done_c = -1; prev = '0;
        tag = $sformatf("v%0d_m%0d", vi, v.money);

        bus.change_money = v.money;
        bus.start = 1'b1;
        if (v.inj_kind == 3) bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        cyc = 1;
        while (cyc < 200) begin
            oc = bus.out_coin;
            if (oc != '0 && prev == '0) begin
                if (nr < 16) begin
                    rise_bit[nr] = bit_of(oc);
                    rise_cyc[nr] = cyc;
                end
                if (!$onehot(oc)) glitch++;
                cur_len = 1;
                nr++;
            end else if (oc != '0) begin
                if (oc != prev) glitch++;
                cur_len++;
            end else if (prev != '0 && nr <= 16) begin
                high_len[nr-1] = cur_len;
            end
            if (!bus.busy) busy_err++;
            if (bus.done) begin
                done_c = cyc;
                break;
            end
            if (cyc == v.inj_cyc && v.inj_kind == 1) bus.abort = 1'b1;
            if (cyc == v.inj_cyc && v.inj_kind == 2) begin
                bus.start = 1'b1;
                bus.change_money = v.inj_money;
            end
            step();
            bus.start = 1'b0;
            bus.abort = 1'b0;
            prev = oc;
            cyc++;
        end
        if (done_c < 0) chk({tag, "_timeout"}, 0, 1);

        chk({tag, "_pulses"}, nr, v.n);
        for (int k = 0; k < v.n && k < nr && k < 16; k++) begin
            chk($sformatf("%s_bit%0d", tag, k), rise_bit[k], int'(v.seq[4*k +: 4]));
            chk($sformatf("%s_high%0d", tag, k), high_len[k], 4);
            if (k == 0) chk({tag, "_latency"}, rise_cyc[0], 2);
            else chk($sformatf("%s_period%0d", tag, k), rise_cyc[k] - rise_cyc[k-1], 8);
        end
        chk({tag, "_done_cyc"}, done_c, v.done_c);
        chk({tag, "_busy_hi"}, busy_err, 0);
        chk({tag, "_glitch"}, glitch, 0);
        chk({tag, "_rem"}, int'(bus.remaining), v.rem);
        chk({tag, "_cnt"}, int'(bus.coin_count), v.cnt);
        step();
        chk({tag, "_busy_lo"}, int'(bus.busy), 0);
        chk({tag, "_done_lo"}, int'(bus.done), 0);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        step();
        chk({tag, "_rem_hold"}, int'(bus.remaining), v.rem);
        chk({tag, "_cnt_hold"}, int'(bus.coin_count), v.cnt);
        chk({tag, "_idle_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        int done_seen;
        checks = 0;
        errors = 0;

        //          money n  seq        done rem cnt inj kind imoney
        vecs[0] = '{8'd0,   0, 32'h0,      1,  0, 0, 0, 0, 8'd0};
        vecs[1] = '{8'd37,  5, 32'h123,    41, 0, 5, 0, 0, 8'd0};
        vecs[2] = '{8'd255, 6, 32'h144444, 49, 0, 6, 0, 0, 8'd0};
        vecs[3] = '{8'd1,   1, 32'h0,      9,  0, 1, 0, 0, 8'd0};
        vecs[4] = '{8'd50,  1, 32'h4,      9,  0, 1, 0, 0, 8'd0};
        vecs[5] = '{8'd99,  8, 32'h1334,   65, 0, 8, 0, 0, 8'd0};
        vecs[6] = '{8'd80,  1, 32'h4,      9, 30, 1, 3, 1, 8'd0};
        vecs[7] = '{8'd10,  1, 32'h2,      9,  0, 1, 3, 2, 8'd5};
        vecs[8] = '{8'd20,  1, 32'h3,      9,  0, 1, 0, 3, 8'd0};

        // Reset with start and abort also high must leave everything cleared.
        sys_rst = 1'b1;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.change_money = 8'd77;
        step();
        step();
        chk("rst_out_coin", int'(bus.out_coin), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_rem", int'(bus.remaining), 0);
        chk("rst_cnt", int'(bus.coin_count), 0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        sys_rst = 1'b0;
        step();
        chk("idle_after_rst_busy", int'(bus.busy), 0);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset in the second cycle of the first pulse.
        bus.change_money = 8'd37;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk("midrst_rise", int'(bus.out_coin), 8);
        step();
        chk("midrst_pulse2", int'(bus.out_coin), 8);
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        chk("midrst_out_coin", int'(bus.out_coin), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_rem", int'(bus.remaining), 0);
        chk("midrst_cnt", int'(bus.coin_count), 0);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done || bus.out_coin != '0) done_seen++;
            step();
        end
        chk("midrst_no_done", done_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 5000000, meaning the number of cycles a coin-eject pulse stays high (minimum 1).
REQ-002 SHALL have parameter GAP_CYCLES, default 5000000, meaning the number of low cycles between consecutive pulses (minimum 1).
REQ-003 SHALL have sys_clk  input  1  as the single system clock; all logic is rising-edge.
REQ-004 SHALL have sys_rst  input  1  as the reset, synchronous and active-high.
REQ-005 SHALL have start  input  1  as a one-cycle request to dispense change_money.
REQ-006 SHALL have change_money  input  8  as the change amount in yuan, sampled only on an accepted start.
REQ-007 SHALL have abort  input  1  as a one-cycle request to stop after the current coin.
REQ-008 SHALL have out_coin  output  5  as one-hot eject pulses: [0]=1, [1]=5, [2]=10, [3]=20, [4]=50 (same bit order as the coin-input bus).
REQ-009 SHALL have busy  output  1  set high from the cycle after an accepted start until the DONE cycle, inclusive.
REQ-010 SHALL have done  output  1  as a one-cycle completion strobe.
REQ-011 SHALL have remaining  output  8  as the amount still to be dispensed.
REQ-012 SHALL have coin_count  output  4  as the number of coins ejected in the current or last transaction.

Function
REQ-013 SHALL implement the FSM states IDLE, SELECT, PULSE, GAP and DONE.
REQ-014 IDLE SHALL accept start by latching remaining<=change_money and clearing coin_count and abort_pending; next state is DONE if change_money==0, else SELECT.
REQ-015 start outside IDLE SHALL be ignored, with no effect on any register.
REQ-016 SELECT SHALL last 1 cycle and choose the largest denomination <=remaining (greedy order 50,20,10,5,1); next state is PULSE, or DONE if abort_pending is set.
REQ-017 PULSE SHALL hold out_coin[sel] high, with all other bits low, for exactly PULSE_CYCLES cycles.
REQ-018 On the last PULSE cycle, remaining SHALL decrease by the denomination and coin_count SHALL increase by 1, saturating at 15.
REQ-019 GAP SHALL hold out_coin==0 for GAP_CYCLES cycles, then go to DONE if remaining==0 or abort_pending is set, else to SELECT.
REQ-020 DONE SHALL last 1 cycle with done=1 and busy=1, then go to IDLE.
REQ-021 remaining and coin_count SHALL hold their values in IDLE until the next accepted start.
REQ-022 Latency SHALL be: start at cycle 0 gives the first out_coin rise at cycle 2.
REQ-023 A full pulse period SHALL be PULSE_CYCLES+GAP_CYCLES+1 cycles, including the SELECT cycle.
REQ-024 abort while busy SHALL set abort_pending; the current pulse is never truncated.
REQ-025 After an abort, remaining SHALL report the undispensed amount.
REQ-026 abort in IDLE SHALL be ignored; start and abort in the same IDLE cycle SHALL accept start and drop abort.
REQ-027 A single timer, sized by $clog2 of the maximum of PULSE_CYCLES and GAP_CYCLES, SHALL be reused by PULSE and GAP, reloading on each state entry.
REQ-028 out_coin, busy and done SHALL be registered outputs, with no combinational path from any input.
REQ-029 The arithmetic SHALL never underflow: the chosen denomination is always <=remaining.
REQ-030 An 8-bit range SHALL fully drain; the worst case is 255, which gives 5x50 + 1x5.

Reset
REQ-031 sys_rst SHALL force state=IDLE, out_coin=0, busy=0, done=0, remaining=0, coin_count=0, abort_pending=0 and timer=0 on the next edge.
REQ-032 Reset SHALL override start and abort in the same cycle.
REQ-033 Reset mid-PULSE SHALL drop out_coin to 0 at that edge, with no completion strobe.

Structure
REQ-034 A shared package SHALL hold the denomination values (1,5,10,20,50), the out_coin bit indices and the FSM state encoding.
REQ-035 The coin-input decoder SHALL reuse the bit indices from that package.
REQ-036 The module SHALL contain one combinational sub-module, coin_select: it maps remaining[7:0] to a one-hot denomination and its value.
REQ-037 The timer and FSM SHALL stay in change_dispenser.

Verification (PULSE_CYCLES=4, GAP_CYCLES=3)
REQ-038 SHALL cover a zero request: start with change_money=0 -> done at cycle 1, out_coin never asserted, coin_count=0.
REQ-039 SHALL cover a mixed request: change_money=37 -> pulses on bits 3,2,1,0,0 in order, each 4 cycles high and at least 3 low, then done, remaining=0, coin_count=5.
REQ-040 SHALL cover the worst case: change_money=255 -> five bit-4 pulses then one bit-1 pulse, then done, remaining=0, coin_count=6.
REQ-041 SHALL cover an abort: change_money=80 with abort during the first pulse -> the 50 pulse completes fully, no further pulses, then done, remaining=30, coin_count=1.
REQ-042 SHALL cover start while busy: change_money=10 in flight plus a second start(5) at cycle 3 -> only one bit-2 pulse and remaining=0; the second start has no effect.
REQ-043 SHALL cover reset mid-operation: sys_rst asserted in the second cycle of a pulse -> out_coin=0, busy=0 and remaining=0 the next cycle, with done never asserted.
